kb_led_ctrl: RTL and testbench
==============================

Name: kb_led_ctrl

Overview:
- Controller between the keyboard receive path (PS/2 receiver, scan-code filter, 9-bit code FIFO) and the PS/2 transmitter.
- Pops codes from the FIFO and forwards them downstream over a valid/ready handshake.
- Tracks Caps/Num/Scroll lock state and sequences the host-to-keyboard Set-LED command pair (0xED, LED byte), with ACK wait, timeout and retry.
- Drives `rx_en` so the transmitter and receiver never own the PS/2 lines at the same time.

Parameters:
- ACK_TIMEOUT, 1000000, cycles to wait for keyboard ACK after each transmitted byte (20 ms at 50 MHz).
- MAX_RETRY, 3, resend attempts per command byte before abort.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- fifo_empty  in  1  code FIFO empty
- rd_data  in  9  FIFO head (first-word-fall-through); bit8 = E0-extended flag, [7:0] = code
- rd_fifo  out  1  one-cycle FIFO pop
- key_valid  out  1  key_code valid
- key_code  out  9  forwarded code
- key_ready  in  1  downstream accepts
- tx_start  out  1  one-cycle transmit request
- tx_data  out  8  byte to transmit
- tx_idle  in  1  transmitter idle
- rx_done_tick  in  1  receiver byte strobe
- rx_data  in  8  received byte (raw receiver output)
- rx_en  out  1  receiver enable
- leds  out  3  {caps, num, scroll}
- led_err  out  1  one-cycle pulse on command abort

Behaviour:
- Reset values: `rd_fifo`=0, `key_valid`=0, `key_code`=0, `tx_start`=0, `tx_data`=0, `rx_en`=1, `leds`=3'b000, `led_err`=0, state IDLE, retry and timeout counters 0.
- IDLE: if !`fifo_empty`, latch `rd_data`, pulse `rd_fifo` the same cycle, go CLASSIFY.
- CLASSIFY (1 cycle):
  - Latched 9'h0FA or 9'h0FE: discard and return to IDLE. These are keyboard responses and are never forwarded.
  - Otherwise go OUT with `key_valid`=1 on the next edge. Latency from pop to `key_valid` is 2 cycles.
  - If the code is 9'h058 / 9'h077 / 9'h07E, toggle caps / num / scroll respectively. The `leds` update is visible with `key_valid`. Extended (bit8=1) versions of these codes do not toggle.
- OUT: hold `key_valid` and `key_code` until `key_valid`&&`key_ready`.
  - On handshake, drop `key_valid`.
  - Go SEND_CMD if the code was a lock key, else IDLE.
- SEND_CMD: wait for `tx_idle`=1, then pulse `tx_start` with `tx_data`=8'hED. Drop `rx_en` from the `tx_start` cycle until `tx_idle` returns to 1, then go WAIT_ACK1 with the timeout counter cleared.
- WAIT_ACK1:
  - `rx_done_tick` with 8'hFA: go SEND_LED.
  - 8'hFE, or counter reaching ACK_TIMEOUT-1: retry SEND_CMD if retry count < MAX_RETRY, else abort.
  - Any other byte is ignored.
- SEND_LED and WAIT_ACK2: same as SEND_CMD and WAIT_ACK1, with `tx_data`={5'b0, caps, num, scroll} (scroll=bit0, num=bit1, caps=bit2). The retry counter is cleared on each new byte.
- WAIT_ACK2 with 8'hFA: return to IDLE.
- Abort: pulse `led_err` for 1 cycle and go IDLE. `leds` keeps its new value.
- Lock keys arriving during SEND/WAIT states stay in the FIFO; the FIFO is not popped outside IDLE. A later lock key restarts a fresh ED sequence carrying the current `leds`.
- `tx_start` is never asserted while `tx_idle`=0. At most one `tx_start` per transmitted byte.
- Reset mid-sequence: everything returns to reset values immediately. A partially sent command is not resumed.
- Counters saturate and never wrap.

Optional Feature:
- Macro: KB_INIT_RESET_EN.
- Defined: after reset, before IDLE, perform the keyboard init sequence:
  - Send 8'hFF under the SEND/WAIT rules, then wait for BAT 8'hAA within 10×ACK_TIMEOUT.
  - 8'hFC, or timeout, gives a `led_err` pulse and then IDLE.
  - The FIFO is not popped during init.
  - Then send ED/8'h00 to sync `leds`.
- Undefined: reset enters IDLE directly. No transmit occurs until the first lock key.

Test Plan:
- FIFO holds 9'h01C, `key_ready`=1 → one `rd_fifo` pulse; `key_valid` 2 cycles later with `key_code`=9'h01C for 1 cycle; no `tx_start`; `leds`=000.
- FIFO holds 9'h058, keyboard model ACKs each byte → `leds`=100; `tx_data` ED then 8'h04; exactly 2 `tx_start` pulses; `rx_en`=0 during each transmission; ends in IDLE.
- 9'h158 (extended) → forwarded, `leds` unchanged, no transmit.
- 9'h077, model answers first ED with FE and then FA → ED sent twice then 8'h02; `led_err` stays 0.
- 9'h07E, model never answers, ACK_TIMEOUT=50 → ED sent 4 times (1+MAX_RETRY) at 50-cycle spacing after `tx_idle`; one `led_err` pulse; `leds`=001; FIFO 9'h0FA entry afterwards is discarded, `key_valid` stays 0.
- Assert `rst_n`=0 during WAIT_ACK2 with `key_ready` held 0 → all outputs reset asynchronously; after release, IDLE with `leds`=000 (or init sequence FF when KB_INIT_RESET_EN is defined).

Source files
------------

// File: rtl/kb_led_ctrl.sv
// kb_led_ctrl: forwards PS/2 codes from the code FIFO and sequences the Set-LED (ED, LED byte) command.
// Define KB_INIT_RESET_EN to run the keyboard reset (FF), BAT wait and LED sync after reset.
module kb_led_ctrl #(
    parameter int ACK_TIMEOUT = 1000000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fifo_empty,
    input  logic [8:0] rd_data,
    output logic       rd_fifo,
    output logic       key_valid,
    output logic [8:0] key_code,
    input  logic       key_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_idle,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic       rx_en,
    output logic [2:0] leds,
    output logic       led_err
);
`ifdef KB_INIT_RESET_EN
    localparam int TMO_MAX = 10 * ACK_TIMEOUT;
`else
    localparam int TMO_MAX = ACK_TIMEOUT;
`endif
    localparam int TW = $clog2(TMO_MAX + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [TW-1:0] ACK_LIM = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_SAT = TW'(TMO_MAX);
    localparam logic [RW-1:0] RTY_MAX = RW'(MAX_RETRY);
`ifdef KB_INIT_RESET_EN
    localparam logic [TW-1:0] BAT_LIM = TW'(TMO_MAX - 1);
`endif

    typedef enum logic [2:0] {IDLE, CLASSIFY, OUT, SEND, XMIT, WAIT_ACK, INIT, WAIT_BAT} state_t;
    typedef enum logic [1:0] {B_CMD, B_LED, B_RST} byte_t;

`ifdef KB_INIT_RESET_EN
    localparam state_t RST_STATE = INIT;
`else
    localparam state_t RST_STATE = IDLE;
`endif

    state_t        state_q, state_d;
    byte_t         sel_q, sel_d;
    logic [8:0]    code_q, code_d;
    logic          lock_q, lock_d;
    logic          key_valid_q, key_valid_d;
    logic [2:0]    leds_q, leds_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
    logic [RW-1:0] retry_q, retry_d;
    logic          led_err_q, led_err_d;
    logic [2:0]    lock_m;

    assign key_valid = key_valid_q;
    assign key_code  = code_q;
    assign tx_data   = tx_data_q;
    assign leds      = leds_q;
    assign led_err   = led_err_q;
    assign tmo_inc   = (tmo_q == TMO_SAT) ? tmo_q : tmo_q + 1'b1;
    // Only non-extended codes toggle: comparing all 9 bits excludes E0 variants.
    assign lock_m    = {code_q == 9'h058, code_q == 9'h077, code_q == 9'h07E};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_STATE;
            sel_q       <= B_CMD;
            code_q      <= '0;
            lock_q      <= 1'b0;
            key_valid_q <= 1'b0;
            leds_q      <= '0;
            tx_data_q   <= '0;
            tmo_q       <= '0;
            retry_q     <= '0;
            led_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            code_q      <= code_d;
            lock_q      <= lock_d;
            key_valid_q <= key_valid_d;
            leds_q      <= leds_d;
            tx_data_q   <= tx_data_d;
            tmo_q       <= tmo_d;
            retry_q     <= retry_d;
            led_err_q   <= led_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        code_d      = code_q;
        lock_d      = lock_q;
        key_valid_d = key_valid_q;
        leds_d      = leds_q;
        tx_data_d   = tx_data_q;
        tmo_d       = tmo_q;
        retry_d     = retry_q;
        led_err_d   = 1'b0;
        rd_fifo     = 1'b0;
        tx_start    = 1'b0;
        rx_en       = 1'b1;
        case (state_q)
            IDLE: if (!fifo_empty) begin
                // Gated so the FIFO is never popped while reset is held.
                rd_fifo = rst_n;
                code_d  = rd_data;
                state_d = CLASSIFY;
            end
            CLASSIFY: if (code_q == 9'h0FA || code_q == 9'h0FE) begin
                state_d = IDLE;
            end else begin
                key_valid_d = 1'b1;
                leds_d      = leds_q ^ lock_m;
                lock_d      = |lock_m;
                state_d     = OUT;
            end
            OUT: if (key_ready) begin
                key_valid_d = 1'b0;
                state_d     = lock_q ? SEND : IDLE;
                sel_d       = B_CMD;
                tx_data_d   = 8'hED;
                retry_d     = '0;
            end
            SEND: if (tx_idle) begin
                tx_start = 1'b1;
                rx_en    = 1'b0;
                state_d  = XMIT;
            end
            XMIT: begin
                rx_en = 1'b0;
                if (tx_idle) begin
                    state_d = WAIT_ACK;
                    tmo_d   = '0;
                end
            end
            WAIT_ACK: begin
                tmo_d = tmo_inc;
                if (rx_done_tick && rx_data == 8'hFA) begin
                    retry_d   = '0;
                    tmo_d     = '0;
                    state_d   = (sel_q == B_LED) ? IDLE : (sel_q == B_RST) ? WAIT_BAT : SEND;
                    sel_d     = B_LED;
                    tx_data_d = {5'b0, leds_q};
                end else if ((rx_done_tick && rx_data == 8'hFE) || tmo_q == ACK_LIM) begin
                    retry_d = retry_q + 1'b1;
                    state_d = SEND;
                    if (retry_q == RTY_MAX) begin
                        retry_d   = retry_q;
                        led_err_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
`ifdef KB_INIT_RESET_EN
            INIT: begin
                state_d   = SEND;
                sel_d     = B_RST;
                tx_data_d = 8'hFF;
                retry_d   = '0;
            end
            WAIT_BAT: begin
                tmo_d = tmo_inc;
                if (rx_done_tick && rx_data == 8'hAA) begin
                    state_d   = SEND;
                    sel_d     = B_CMD;
                    tx_data_d = 8'hED;
                    retry_d   = '0;
                end else if ((rx_done_tick && rx_data == 8'hFC) || tmo_q == BAT_LIM) begin
                    led_err_d = 1'b1;
                    state_d   = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_kb_led_ctrl.sv
// tb_kb_led_ctrl: directed bench with FIFO, transmitter and keyboard models plus a transaction scoreboard.
module tb_kb_led_ctrl;
    localparam int ACK_TIMEOUT = 50;
    localparam int MAX_RETRY   = 3;
    localparam int P_ACK = 0, P_FE1 = 1, P_SIL = 2, P_HALF = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fifo_empty;
    logic [8:0] rd_data;
    logic       rd_fifo;
    logic       key_valid;
    logic [8:0] key_code;
    logic       key_ready = 1'b1;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_idle = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_en;
    logic [2:0] leds;
    logic       led_err;

    kb_led_ctrl #(.ACK_TIMEOUT(ACK_TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .rd_data(rd_data), .rd_fifo(rd_fifo),
        .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready), .tx_start(tx_start),
        .tx_data(tx_data), .tx_idle(tx_idle), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .rx_en(rx_en), .leds(leds), .led_err(led_err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    logic [8:0]  fifo_mem [16];
    int          fifo_hd = 0, fifo_tl = 0;
    logic [8:0]  resp_mem [16];
    int          resp_rd = 0, resp_wr = 0;
    logic [11:0] ek_mem [16];
    int          ek_rd = 0, ek_wr = 0;
    logic [7:0]  et_mem [64];
    int          et_rd = 0, et_wr = 0;
    logic [2:0]  mleds = 3'b000;
    int          exp_err = 0;
    int          tx_cnt = 0, err_cnt = 0, pops = 0, kv_cycles = 0;
    int          pop_cyc = 0, kv_rise = 0, idle_rise = 0;
    logic [7:0]  tx_log [64];
    int          gaps [64];
    logic        s_start = 1'b0, s_rd = 1'b0, idle_prev = 1'b1, kv_prev = 1'b0;
    int          busy = 0, rx_wait = 0;
    logic [8:0]  rx_byte = 9'h100;

    assign fifo_empty = (fifo_hd == fifo_tl);
    assign rd_data    = fifo_mem[fifo_hd[3:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FIFO pop, transmitter busy window and keyboard replies, all applied just after the edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        rx_done_tick = 1'b0;
        if (!rst_n) begin
            busy = 0; rx_wait = 0; tx_idle = 1'b1; resp_rd = resp_wr; fifo_hd = fifo_tl;
        end else begin
            if (s_rd) fifo_hd++;
            if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    tx_idle = 1'b1;
                    if (resp_rd != resp_wr) begin
                        rx_byte = resp_mem[resp_rd % 16];
                        resp_rd++;
                        if (!rx_byte[8]) rx_wait = 3;
                    end
                end
            end else if (s_start) begin
                busy = 8; tx_idle = 1'b0;
            end
            if (rx_wait > 0) begin
                rx_wait--;
                if (rx_wait == 0) begin
                    rx_done_tick = 1'b1; rx_data = rx_byte[7:0];
                end
            end
        end
    end

    // Compare process: scoreboard and line-ownership rules every cycle.
    always @(negedge clk) begin
        s_start = tx_start;
        s_rd    = rd_fifo;
        if (rst_n) begin
            if (rd_fifo) begin
                chk("pop_nonempty", 32'(fifo_empty), 0);
                pops++; pop_cyc = cyc;
            end
            if (key_valid && !kv_prev) kv_rise = cyc;
            if (key_valid) kv_cycles++;
            if (key_valid && key_ready) begin
                if (ek_rd == ek_wr) begin
                    checks++; errors++;
                    $display("FAIL key_extra: got %0h expected none", key_code);
                end else begin
                    chk("key_code", 32'(key_code), 32'(ek_mem[ek_rd % 16][8:0]));
                    chk("leds_at_key", 32'(leds), 32'(ek_mem[ek_rd % 16][11:9]));
                    ek_rd++;
                end
            end
            if (tx_start) begin
                chk("start_when_idle", 32'(tx_idle), 1);
                chk("rx_en_at_start", 32'(rx_en), 0);
                if (et_rd == et_wr) begin
                    checks++; errors++;
                    $display("FAIL tx_extra: got %0h expected none", tx_data);
                end else begin
                    chk("tx_data", 32'(tx_data), 32'(et_mem[et_rd % 64]));
                    et_rd++;
                end
                tx_log[tx_cnt % 64] = tx_data;
                gaps[tx_cnt % 64] = cyc - idle_rise;
                tx_cnt++;
            end
            if (!tx_idle) chk("rx_en_while_tx", 32'(rx_en), 0);
            if (led_err) err_cnt++;
            if (tx_idle && !idle_prev) idle_rise = cyc;
        end else begin
            ek_rd = ek_wr; et_rd = et_wr;
        end
        idle_prev = tx_idle;
        kv_prev   = key_valid;
    end

    task automatic add_tx(input logic [7:0] b, input logic [8:0] r);
        et_mem[et_wr % 64] = b; et_wr++;
        resp_mem[resp_wr % 16] = r; resp_wr++;
    endtask

    // Model: what a FIFO entry must produce downstream, given how the keyboard answers.
    task automatic model_key(input logic [8:0] c, input int plan);
        logic [2:0] m;
        if (c == 9'h0FA || c == 9'h0FE) return;
        m = {c == 9'h058, c == 9'h077, c == 9'h07E};
        mleds = mleds ^ m;
        ek_mem[ek_wr % 16] = {mleds, c}; ek_wr++;
        if (m == 3'b000) return;
        case (plan)
            P_ACK: begin add_tx(8'hED, 9'h0FA); add_tx({5'b0, mleds}, 9'h0FA); end
            P_FE1: begin add_tx(8'hED, 9'h0FE); add_tx(8'hED, 9'h0FA); add_tx({5'b0, mleds}, 9'h0FA); end
            P_SIL: begin
                for (int i = 0; i <= MAX_RETRY; i++) add_tx(8'hED, 9'h100);
                exp_err++;
            end
            default: begin add_tx(8'hED, 9'h0FA); add_tx({5'b0, mleds}, 9'h100); end
        endcase
    endtask

    task automatic push(input logic [8:0] c, input int plan);
        @(posedge clk); #2;
        fifo_mem[fifo_tl % 16] = c; fifo_tl++;
        model_key(c, plan);
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0; mleds = 3'b000; exp_err = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic all_seen(input string p, input int e0);
        chk({p, "_tx_all_sent"}, 32'(et_rd), 32'(et_wr));
        chk({p, "_keys_all_seen"}, 32'(ek_rd), 32'(ek_wr));
        chk({p, "_led_err_pulses"}, 32'(err_cnt - e0), 32'(exp_err));
    endtask

    int tx0, e0, kv0, p0;

    initial begin
        #3;
        chk("rst_rd_fifo", 32'(rd_fifo), 0);
        chk("rst_key_valid", 32'(key_valid), 0);
        chk("rst_key_code", 32'(key_code), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_rx_en", 32'(rx_en), 1);
        chk("rst_leds", 32'(leds), 0);
        chk("rst_led_err", 32'(led_err), 0);
        @(posedge clk); #2 rst_n = 1'b1;

        // Plain key: forwarded once, no transmit.
        tx0 = tx_cnt; e0 = err_cnt; kv0 = kv_cycles;
        push(9'h01C, P_ACK);
        run(60);
        chk("t1_latency", 32'(kv_rise - pop_cyc), 2);
        chk("t1_valid_cycles", 32'(kv_cycles - kv0), 1);
        chk("t1_tx_count", 32'(tx_cnt - tx0), 0);
        chk("t1_leds", 32'(leds), 0);
        all_seen("t1", e0);

        // Caps lock, every byte acknowledged.
        do_reset();
        tx0 = tx_cnt; e0 = err_cnt;
        push(9'h058, P_ACK);
        run(200);
        chk("t2_leds", 32'(leds), 32'(3'b100));
        chk("t2_tx_count", 32'(tx_cnt - tx0), 2);
        chk("t2_byte0", 32'(tx_log[tx0 % 64]), 32'h0ED);
        chk("t2_byte1", 32'(tx_log[(tx0 + 1) % 64]), 32'h004);
        all_seen("t2", e0);

        // Extended caps code: forwarded, no toggle.
        tx0 = tx_cnt; e0 = err_cnt;
        push(9'h158, P_ACK);
        run(60);
        chk("t3_leds", 32'(leds), 32'(3'b100));
        chk("t3_tx_count", 32'(tx_cnt - tx0), 0);
        all_seen("t3", e0);

        // Num lock, first ED rejected once.
        do_reset();
        tx0 = tx_cnt; e0 = err_cnt;
        push(9'h077, P_FE1);
        run(250);
        chk("t4_tx_count", 32'(tx_cnt - tx0), 3);
        chk("t4_byte2", 32'(tx_log[(tx0 + 2) % 64]), 32'h002);
        chk("t4_led_err", 32'(err_cnt - e0), 0);
        chk("t4_leds", 32'(leds), 32'(3'b010));
        all_seen("t4", e0);

        // Scroll lock, keyboard silent: retries exhaust and abort.
        do_reset();
        tx0 = tx_cnt; e0 = err_cnt;
        push(9'h07E, P_SIL);
        run(400);
        chk("t5_tx_count", 32'(tx_cnt - tx0), 32'(1 + MAX_RETRY));
        chk("t5_led_err", 32'(err_cnt - e0), 1);
        chk("t5_leds", 32'(leds), 32'(3'b001));
        for (int i = 1; i <= MAX_RETRY; i++) begin
            checks++;
            if (gaps[(tx0 + i) % 64] < ACK_TIMEOUT || gaps[(tx0 + i) % 64] > ACK_TIMEOUT + 2) begin
                errors++;
                $display("FAIL t5_retry_gap%0d: got %0d expected %0d..%0d", i, gaps[(tx0 + i) % 64], ACK_TIMEOUT, ACK_TIMEOUT + 2);
            end
        end
        all_seen("t5", e0);
        kv0 = kv_cycles; p0 = pops;
        push(9'h0FA, P_ACK);
        run(30);
        chk("t5_fa_no_valid", 32'(kv_cycles - kv0), 0);
        chk("t5_fa_popped", 32'(pops - p0), 1);
        chk("t5_fa_fifo_empty", 32'(fifo_empty), 1);

        // Async reset while waiting for the LED-byte ACK.
        do_reset();
        tx0 = tx_cnt; e0 = err_cnt;
        push(9'h058, P_HALF);
        run(40);
        key_ready = 1'b0;
        run(5);
        chk("t6_pre_tx_count", 32'(tx_cnt - tx0), 2);
        chk("t6_pre_leds", 32'(leds), 32'(3'b100));
        all_seen("t6", e0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_leds", 32'(leds), 0);
        chk("t6_rst_tx_data", 32'(tx_data), 0);
        chk("t6_rst_key_code", 32'(key_code), 0);
        chk("t6_rst_rx_en", 32'(rx_en), 1);
        chk("t6_rst_key_valid", 32'(key_valid), 0);
        chk("t6_rst_tx_start", 32'(tx_start), 0);
        @(posedge clk); #2 rst_n = 1'b1;
        key_ready = 1'b1;
        tx0 = tx_cnt; e0 = err_cnt;
        run(100);
        chk("t6_post_tx_count", 32'(tx_cnt - tx0), 0);
        chk("t6_post_leds", 32'(leds), 0);
        chk("t6_post_led_err", 32'(err_cnt - e0), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
